// File: rtl/wb_commit_unit_pkg.sv
// Shared widths, the write-request record and the x0 address used by the
// writeback commit unit and its result FIFO.
package wb_commit_unit_pkg;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;

    localparam logic [ADDR_W-1:0] RegZero = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_commit_unit_result_fifo.sv
// Synchronous FIFO of long-latency write requests with occupancy count.
// Pushes while full and pops while empty are ignored.
module wb_result_fifo
    import wb_commit_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     i_Push,
    input  wb_req_t                  i_PushData,
    input  logic                     i_Pop,
    output wb_req_t                  o_Head,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t              r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W:0]       r_count;
    logic                 w_doPush;
    logic                 w_doPop;

    assign o_Full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_Empty  = (r_count == '0);
    assign o_Count  = r_count;
    assign o_Head   = r_mem[r_rdPtr];
    assign w_doPush = i_Push && !o_Full;
    assign w_doPop  = i_Pop && !o_Empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            if (w_doPush && !w_doPop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (w_doPop && !w_doPush) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_PushData;
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Register-file write-port owner: arbitrates pipeline and buffered long-latency
// results, with anti-starvation for the FIFO and a per-register busy scoreboard.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          i_PipeValid,
    input  logic [ADDR_W-1:0]             i_PipeAddr,
    input  logic [DATA_W-1:0]             i_PipeData,
    output logic                          o_PipeStall,
    input  logic                          i_LongValid,
    output logic                          o_LongReady,
    input  logic [ADDR_W-1:0]             i_LongAddr,
    input  logic [DATA_W-1:0]             i_LongData,
    input  logic                          i_IssueMarkValid,
    input  logic [ADDR_W-1:0]             i_IssueMarkAddr,
    input  logic [ADDR_W-1:0]             i_Rs1QueryAddr,
    output logic                          o_Rs1Busy,
    input  logic [ADDR_W-1:0]             i_Rs2QueryAddr,
    output logic                          o_Rs2Busy,
    output logic [DATA_W-1:0]             o_RdWriteData,
    output logic [ADDR_W-1:0]             o_RdWriteAddr,
    output logic                          o_RdWriteEnable,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoCount,
    output logic                          o_Idle
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                 w_head;
    wb_req_t                 w_pipeReq;
    wb_req_t                 w_win;
    logic                    w_fifoFull;
    logic                    w_fifoEmpty;
    logic                    w_push;
    logic                    w_starveWin;
    logic                    w_fifoWin;
    logic                    w_winValid;
    logic [REG_NUM-1:0]      w_busyNext;

    logic [STARVE_W-1:0]     r_starve;
    logic [REG_NUM-1:0]      r_busy;
    logic [DATA_W-1:0]       r_RdWriteData;
    logic [ADDR_W-1:0]       r_RdWriteAddr;
    logic                    r_RdWriteEnable;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_Push     (w_push),
        .i_PushData (wb_req_t'{addr: i_LongAddr, data: i_LongData}),
        .i_Pop      (w_fifoWin),
        .o_Head     (w_head),
        .o_Count    (o_FifoCount),
        .o_Full     (w_fifoFull),
        .o_Empty    (w_fifoEmpty)
    );

    // Ready and stall come from registered state only, so a same-cycle pop
    // never opens the FIFO and the stall never depends on PipeValid.
    assign o_LongReady = !w_fifoFull;
    assign w_push      = i_LongValid && o_LongReady;
    assign w_starveWin = !w_fifoEmpty && (r_starve == STARVE_W'(STARVE_LIMIT));
    assign o_PipeStall = w_starveWin;
    assign w_fifoWin   = !w_fifoEmpty && (w_starveWin || !i_PipeValid);
    assign w_winValid  = w_fifoWin || i_PipeValid;
    assign w_pipeReq   = '{addr: i_PipeAddr, data: i_PipeData};
    assign w_win       = w_fifoWin ? w_head : w_pipeReq;

    assign o_Rs1Busy       = (i_Rs1QueryAddr != RegZero) && r_busy[i_Rs1QueryAddr];
    assign o_Rs2Busy       = (i_Rs2QueryAddr != RegZero) && r_busy[i_Rs2QueryAddr];
    assign o_RdWriteData   = r_RdWriteData;
    assign o_RdWriteAddr   = r_RdWriteAddr;
    assign o_RdWriteEnable = r_RdWriteEnable;
    assign o_Idle          = w_fifoEmpty && (r_busy == '0) && !r_RdWriteEnable;

    // The mark is applied after the clear so a same-cycle re-issue keeps rd busy.
    always_comb begin
        w_busyNext = r_busy;
        if (w_winValid) w_busyNext[w_win.addr] = 1'b0;
        if (i_IssueMarkValid && (i_IssueMarkAddr != RegZero)) w_busyNext[i_IssueMarkAddr] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_starve        <= '0;
            r_busy          <= '0;
            r_RdWriteData   <= '0;
            r_RdWriteAddr   <= '0;
            r_RdWriteEnable <= 1'b0;
        end else begin
            r_busy          <= w_busyNext;
            r_RdWriteEnable <= w_winValid && (w_win.addr != RegZero);
            if (w_winValid) begin
                r_RdWriteData <= w_win.data;
                r_RdWriteAddr <= w_win.addr;
            end
            if (w_fifoEmpty || w_fifoWin) r_starve <= '0;
            else                          r_starve <= r_starve + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomized and directed bench for wb_commit_unit: a queue-based model predicts
// each write, and a separate monitor checks the write port against it.
module tb_wb_commit_unit;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 3;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        i_PipeValid;
    logic [4:0]  i_PipeAddr;
    logic [63:0] i_PipeData;
    logic        o_PipeStall;
    logic        i_LongValid;
    logic        o_LongReady;
    logic [4:0]  i_LongAddr;
    logic [63:0] i_LongData;
    logic        i_IssueMarkValid;
    logic [4:0]  i_IssueMarkAddr;
    logic [4:0]  i_Rs1QueryAddr;
    logic        o_Rs1Busy;
    logic [4:0]  i_Rs2QueryAddr;
    logic        o_Rs2Busy;
    logic [63:0] o_RdWriteData;
    logic [4:0]  o_RdWriteAddr;
    logic        o_RdWriteEnable;
    logic [2:0]  o_FifoCount;
    logic        o_Idle;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    ent_t        mQ[$];
    exp_t        expQ[$];
    int          mStarve = 0;
    logic [31:0] mBusy = '0;
    bit          mLastWrite = 0;

    wb_commit_unit #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .i_PipeValid      (i_PipeValid),
        .i_PipeAddr       (i_PipeAddr),
        .i_PipeData       (i_PipeData),
        .o_PipeStall      (o_PipeStall),
        .i_LongValid      (i_LongValid),
        .o_LongReady      (o_LongReady),
        .i_LongAddr       (i_LongAddr),
        .i_LongData       (i_LongData),
        .i_IssueMarkValid (i_IssueMarkValid),
        .i_IssueMarkAddr  (i_IssueMarkAddr),
        .i_Rs1QueryAddr   (i_Rs1QueryAddr),
        .o_Rs1Busy        (o_Rs1Busy),
        .i_Rs2QueryAddr   (i_Rs2QueryAddr),
        .o_Rs2Busy        (o_Rs2Busy),
        .o_RdWriteData    (o_RdWriteData),
        .o_RdWriteAddr    (o_RdWriteAddr),
        .o_RdWriteEnable  (o_RdWriteEnable),
        .o_FifoCount      (o_FifoCount),
        .o_Idle           (o_Idle)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    // Write port checker: every cycle the enable must match whether a write is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            checkOutput("RdWriteEnable", o_RdWriteEnable, (expQ.size() != 0) && (expQ[0].due == cycle));
            if (o_RdWriteEnable && expQ.size() != 0 && expQ[0].due == cycle) begin
                e = expQ.pop_front();
                checkOutput("RdWriteAddr", o_RdWriteAddr, e.addr);
                checkOutput("RdWriteData", o_RdWriteData, e.data);
            end
        end
    end

    task automatic applyStimulus(input bit pv, input logic [4:0] pa, input logic [63:0] pd,
                                 input bit lv, input logic [4:0] la, input logic [63:0] ld,
                                 input bit mv, input logic [4:0] ma,
                                 input logic [4:0] q1, input logic [4:0] q2,
                                 output bit pipeTaken, output bit longTaken);
        ent_t win;
        bit   haveWin;
        bit   stall;
        bit   ready;
        int   sizeBefore;
        @(negedge Clk);
        i_PipeValid = pv;       i_PipeAddr = pa;       i_PipeData = pd;
        i_LongValid = lv;       i_LongAddr = la;       i_LongData = ld;
        i_IssueMarkValid = mv;  i_IssueMarkAddr = ma;
        i_Rs1QueryAddr = q1;    i_Rs2QueryAddr = q2;
        #1;
        sizeBefore = mQ.size();
        stall = (sizeBefore != 0) && (mStarve == STARVE_LIMIT);
        ready = sizeBefore < FIFO_DEPTH;
        checkOutput("PipeStall", o_PipeStall, stall);
        checkOutput("LongReady", o_LongReady, ready);
        checkOutput("FifoCount", o_FifoCount, sizeBefore);
        checkOutput("Rs1Busy", o_Rs1Busy, (q1 != 0) && mBusy[q1]);
        checkOutput("Rs2Busy", o_Rs2Busy, (q2 != 0) && mBusy[q2]);
        checkOutput("Idle", o_Idle, (sizeBefore == 0) && (mBusy == 0) && !mLastWrite);
        haveWin = 0;
        pipeTaken = 0;
        if (stall || (!pv && sizeBefore != 0)) begin
            win = mQ.pop_front();
            haveWin = 1;
            mStarve = 0;
        end else begin
            if (pv) begin
                win = '{addr: pa, data: pd};
                haveWin = 1;
                pipeTaken = 1;
            end
            mStarve = (sizeBefore != 0) ? mStarve + 1 : 0;
        end
        longTaken = lv && ready;
        if (longTaken) mQ.push_back('{addr: la, data: ld});
        if (haveWin) mBusy[win.addr] = 1'b0;
        if (mv && ma != 0) mBusy[ma] = 1'b1;
        mLastWrite = haveWin && (win.addr != 0);
        if (mLastWrite) expQ.push_back('{due: cycle + 1, addr: win.addr, data: win.data});
    endtask

    task automatic idleCycles(input int n);
        bit pt, lt;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pt, lt);
    endtask

    task automatic resetMidOp();
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        i_Rs1QueryAddr = 5'd3;
        i_Rs2QueryAddr = 5'd4;
        #1;
        checkOutput("reset_RdWriteEnable", o_RdWriteEnable, 0);
        checkOutput("reset_FifoCount", o_FifoCount, 0);
        checkOutput("reset_Idle", o_Idle, 1);
        checkOutput("reset_Rs1Busy", o_Rs1Busy, 0);
        checkOutput("reset_Rs2Busy", o_Rs2Busy, 0);
        mQ.delete();
        expQ.delete();
        mBusy = '0;
        mStarve = 0;
        mLastWrite = 0;
        i_PipeValid = 0;
        i_LongValid = 0;
        i_IssueMarkValid = 0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        bit          pt, lt;
        bit          pv, lv, mv, pHeld, lHeld;
        logic [4:0]  pa, la, ma, q1, q2;
        logic [63:0] pd, ld;
        int          addr, lAddr;

        Rst = 1'b0;
        i_PipeValid = 0; i_PipeAddr = 0; i_PipeData = 0;
        i_LongValid = 0; i_LongAddr = 0; i_LongData = 0;
        i_IssueMarkValid = 0; i_IssueMarkAddr = 0;
        i_Rs1QueryAddr = 0; i_Rs2QueryAddr = 0;
        repeat (3) @(negedge Clk);
        checkOutput("rst_RdWriteEnable", o_RdWriteEnable, 0);
        checkOutput("rst_RdWriteAddr", o_RdWriteAddr, 0);
        checkOutput("rst_RdWriteData", o_RdWriteData, 0);
        checkOutput("rst_FifoCount", o_FifoCount, 0);
        checkOutput("rst_PipeStall", o_PipeStall, 0);
        checkOutput("rst_LongReady", o_LongReady, 1);
        checkOutput("rst_Idle", o_Idle, 1);
        Rst = 1'b1;

        // Pipe only, then a single long result.
        applyStimulus(1, 5, 64'hDEAD, 0, 0, 0, 0, 0, 0, 0, pt, lt);
        idleCycles(2);
        applyStimulus(0, 0, 0, 1, 7, 64'h1234, 0, 0, 0, 0, pt, lt);
        idleCycles(3);

        // Keep the pipe busy so the FIFO fills until ready drops.
        addr = 20;
        lAddr = 1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 5'(addr), 64'(k + 100), 1, 5'(lAddr), 64'hA000 + 64'(lAddr), 0, 0, 0, 0, pt, lt);
            if (k == 4) begin
                checkOutput("full_LongReady", o_LongReady, 0);
                checkOutput("full_FifoCount", o_FifoCount, 4);
            end
            if (pt) addr++;
            if (lt) lAddr++;
        end
        idleCycles(6);

        // Starvation: one FIFO entry against a continuous pipe stream.
        addr = 20;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 5'(addr), 64'hB000 + 64'(addr), k == 0, 9, 64'h9999, 0, 0, 0, 0, pt, lt);
            if (k == 4) checkOutput("starve_PipeStall", o_PipeStall, 1);
            if (pt) addr++;
        end
        idleCycles(3);

        // Scoreboard set/clear, including a re-mark in the commit cycle.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 1, 12, 64'h1212, 0, 0, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 1, 12, 64'h3434, 0, 0, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, pt, lt);
        checkOutput("mark_wins_Rs1Busy", o_Rs1Busy, 1);

        // x0 writes, marks and FIFO entries.
        applyStimulus(1, 0, 64'hFF, 0, 0, 0, 0, 0, 0, 0, pt, lt);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, pt, lt);
        applyStimulus(0, 0, 0, 1, 0, 64'h77, 0, 0, 0, 0, pt, lt);
        idleCycles(3);

        // Reset while the FIFO holds entries and registers are busy.
        applyStimulus(1, 21, 64'h21, 1, 13, 64'h13, 1, 3, 0, 0, pt, lt);
        applyStimulus(1, 22, 64'h22, 1, 14, 64'h14, 1, 4, 0, 0, pt, lt);
        applyStimulus(1, 23, 64'h23, 1, 15, 64'h15, 0, 0, 3, 4, pt, lt);
        applyStimulus(1, 25, 64'h25, 0, 0, 0, 0, 0, 3, 4, pt, lt);
        resetMidOp();
        idleCycles(3);

        // Randomized traffic with upstream holding unaccepted results.
        pHeld = 0;
        lHeld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pHeld) begin
                pv = ($urandom_range(0, 99) < 60);
                pa = 5'($urandom_range(0, 31));
                pd = {$urandom, $urandom};
            end
            if (!lHeld) begin
                lv = ($urandom_range(0, 99) < 45);
                la = 5'($urandom_range(0, 31));
                ld = {$urandom, $urandom};
            end
            mv = ($urandom_range(0, 99) < 40);
            ma = 5'($urandom_range(0, 31));
            q1 = ($urandom_range(0, 3) == 0) ? ma : 5'($urandom_range(0, 31));
            q2 = 5'($urandom_range(0, 31));
            applyStimulus(pv, pa, pd, lv, la, ld, mv, ma, q1, q2, pt, lt);
            pHeld = pv && !pt;
            lHeld = lv && !lt;
            if (i == 200) begin
                resetMidOp();
                pHeld = 0;
                lHeld = 0;
            end
        end
        idleCycles(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
